// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the decoupled instruction fetch stage.
package instr_fetch_unit_pkg;

    // Fetch control states: BOOT idles one cycle after reset, RUN issues normally,
    // SQUASH issues on the new path while wrong-path responses drain.
    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        SQUASH = 2'b10
    } fetch_state_e;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch stage and I-memory.
interface instr_fetch_unit_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] Iaddr;
    logic          req_i_valid;
    logic          req_i_ready;
    logic [DW-1:0] Iin;
    logic          resp_i_valid;

    modport master (
        output Iaddr, req_i_valid,
        input  req_i_ready, Iin, resp_i_valid
    );

    modport slave (
        input  Iaddr, req_i_valid,
        output req_i_ready, Iin, resp_i_valid
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous FIFO used both for in-flight request PCs and for returned
// {instruction, PC} words. Flush beats push and pop; a full queue still
// accepts a push in a cycle that also pops.
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against occupancy and flush
    always_comb begin
        do_pop_s  = pop & ~empty & ~flush;
        do_push_s = push & ~flush & (~full | do_pop_s);
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage write; contents need no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled IF stage: pipelined in-order I-memory requests with credit-based
// issue, a DEPTH-entry return queue, and wrong-path squashing on redirect.
// Optional feature macro: FETCH_BYPASS_EN (response forwarded straight to the
// outputs when the return queue is empty).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic               CLK,
    input  logic               RESET,
    instr_fetch_unit_if.master mem,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_pc,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [DW-1:0]      ins_out,
    output logic [AW-1:0]      pc_out,
    output logic [AW-1:0]      pcplus4_out
);
    localparam int unsigned   CW      = cnt_w(DEPTH);
    localparam int unsigned   CW1     = CW + 1;
    localparam logic [AW-1:0] PC_STEP = AW'(32'd4);

    fetch_state_e     state_r;
    fetch_state_e     state_nxt_s;
    logic [AW-1:0]    pc_r;
    logic [CW-1:0]    squash_cnt_r;
    logic [CW-1:0]    squash_nxt_s;
    logic [CW-1:0]    squash_after_s;
    logic [CW-1:0]    live_after_s;
    logic [CW-1:0]    live_cnt_s;   // live in-flight requests == PC queue occupancy
    logic [CW-1:0]    q_count_s;
    logic [CW1-1:0]   fill_s;
    logic [CW1-1:0]   commit_s;
    logic             pcq_full_s;
    logic             pcq_empty_s;
    logic             q_full_s;
    logic             q_empty_s;
    logic [AW-1:0]    pcq_head_s;
    logic [DW+AW-1:0] q_rdata_s;
    logic             issue_s;
    logic             fire_s;
    logic             resp_old_s;
    logic             resp_live_s;
    logic             push_s;
    logic             pop_s;
    logic             byp_s;
    logic             ins_valid_s;

    // Issue credit, response classification and dequeue handshake
    always_comb begin
        fill_s      = {1'b0, live_cnt_s} + {1'b0, q_count_s};
        commit_s    = {1'b0, live_cnt_s} + {1'b0, squash_cnt_r};
        issue_s     = ~RESET & (state_r != BOOT) & ~redirect_valid
                    & (fill_s < CW1'(DEPTH)) & (commit_s < CW1'(DEPTH))
                    & ~pcq_full_s & ~q_full_s;
        fire_s      = issue_s & mem.req_i_ready;
        resp_old_s  = mem.resp_i_valid & (squash_cnt_r != {CW{1'b0}});
        resp_live_s = mem.resp_i_valid & (squash_cnt_r == {CW{1'b0}}) & ~pcq_empty_s;
`ifdef FETCH_BYPASS_EN
        byp_s       = ~RESET & ~redirect_valid & q_empty_s & resp_live_s;
        push_s      = resp_live_s & ~redirect_valid & ~(byp_s & ins_ready);
`else
        byp_s       = 1'b0;
        push_s      = resp_live_s & ~redirect_valid;
`endif
        ins_valid_s = ~RESET & ~redirect_valid & (~q_empty_s | byp_s);
        pop_s       = ins_valid_s & ins_ready & ~q_empty_s;
    end

    // Squash accounting and FSM next state; a redirect turns every request still
    // live after this cycle's response into one to be squashed
    always_comb begin
        live_after_s   = live_cnt_s - CW'(resp_live_s);
        squash_after_s = squash_cnt_r - CW'(resp_old_s);
        if (redirect_valid) begin
            squash_nxt_s = squash_after_s + live_after_s;
        end else begin
            squash_nxt_s = squash_after_s;
        end
        state_nxt_s = state_r;
        case (state_r)
            BOOT: state_nxt_s = RUN;
            RUN, SQUASH: begin
                if (squash_nxt_s != {CW{1'b0}}) begin
                    state_nxt_s = SQUASH;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = BOOT;
        endcase
    end

    // FSM state and squash counter registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= BOOT;
            squash_cnt_r <= {CW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            squash_cnt_r <= squash_nxt_s;
        end
    end

    // Fetch PC: reload on redirect, advance by one word per accepted request
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= redirect_pc;
        end else if (fire_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

    fetch_queue #(.W(AW), .DEPTH(DEPTH)) u_pc_queue (
        .clk   (CLK),
        .rst   (RESET),
        .push  (fire_s),
        .pop   (resp_live_s),
        .flush (redirect_valid),
        .wdata (pc_r),
        .rdata (pcq_head_s),
        .full  (pcq_full_s),
        .empty (pcq_empty_s),
        .count (live_cnt_s)
    );

    fetch_queue #(.W(DW + AW), .DEPTH(DEPTH)) u_ins_queue (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .wdata ({mem.Iin, pcq_head_s}),
        .rdata (q_rdata_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    assign mem.Iaddr       = pc_r;
    assign mem.req_i_valid = issue_s;
    assign ins_valid       = ins_valid_s;
`ifdef FETCH_BYPASS_EN
    assign ins_out = byp_s ? mem.Iin : q_rdata_s[DW+AW-1:AW];
    assign pc_out  = byp_s ? pcq_head_s : q_rdata_s[AW-1:0];
`else
    assign ins_out = q_rdata_s[DW+AW-1:AW];
    assign pc_out  = q_rdata_s[AW-1:0];
`endif
    assign pcplus4_out = pc_out + PC_STEP;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: an in-order memory model with
// configurable latency, and a scoreboard of accepted-but-undelivered fetches
// that is cleared on redirect/reset.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ins_ready = 1'b0;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic [31:0] pcplus4_out;

    instr_fetch_unit_if #(.AW(32), .DW(32)) mem_bus ();

    instr_fetch_unit #(.AW(32), .DW(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK            (clk),
        .RESET          (RESET),
        .mem            (mem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_out        (ins_out),
        .pc_out         (pc_out),
        .pcplus4_out    (pcplus4_out)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    mreq_t       mem_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          resp_en = 1'b1;
    int          n_del = 0;
    int          n_acc = 0;
    int          first_acc_cyc = -1;
    int          first_del_cyc = -1;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] last_del_pc = 32'h0;
    logic        obs_req_valid;
    logic        obs_ins_valid;
    logic        obs_resp;
    logic [31:0] obs_iaddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs and memory response, sample, score.
    task automatic cycle(input logic rst, input logic rdy, input logic irdy,
                         input logic redir, input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        RESET = rst;
        mem_bus.req_i_ready = rdy;
        ins_ready = irdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        if (rst) begin
            mem_q.delete();
            mem_bus.resp_i_valid = 1'b0;
            mem_bus.Iin = 32'h0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc && resp_en) begin
            mem_bus.resp_i_valid = 1'b1;
            mem_bus.Iin = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            mem_bus.resp_i_valid = 1'b0;
            mem_bus.Iin = 32'h0;
        end
        #1;
        obs_req_valid = mem_bus.req_i_valid;
        obs_ins_valid = ins_valid;
        obs_resp      = mem_bus.resp_i_valid;
        obs_iaddr     = mem_bus.Iaddr;
        if (rst || redir) begin
            tests_run++;
            if (ins_valid !== 1'b0 || mem_bus.req_i_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL quiet_cycle: ins_valid=%b req_i_valid=%b expected 0/0 (rst=%b redir=%b)",
                         ins_valid, mem_bus.req_i_valid, rst, redir);
            end
        end
        if (ins_valid === 1'b1 && irdy) begin
            n_del++;
            last_del_pc = pc_out;
            if (first_del_cyc < 0) first_del_cyc = cyc;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL deliver_extra: pc_out=%h delivered with nothing expected", pc_out);
            end else begin
                e = sb.pop_front();
                if (pc_out !== e.pc || ins_out !== e.word || pcplus4_out !== e.pc + 32'd4) begin
                    tests_failed++;
                    $display("FAIL deliver: pc_out=%h ins_out=%h pcplus4=%h expected %h %h %h",
                             pc_out, ins_out, pcplus4_out, e.pc, e.word, e.pc + 32'd4);
                end
            end
        end
        if (mem_bus.req_i_valid === 1'b1) begin
            tests_run++;
            if (mem_bus.Iaddr !== model_pc) begin
                tests_failed++;
                $display("FAIL iaddr: Iaddr=%h expected %h", mem_bus.Iaddr, model_pc);
            end
            if (rdy) begin
                e.pc = model_pc;
                e.word = mem_word(model_pc);
                sb.push_back(e);
                mem_q.push_back('{addr: mem_bus.Iaddr, due: cyc + lat});
                model_pc = model_pc + 32'd4;
                n_acc++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
        end
        if (rst) begin
            sb.delete();
            model_pc = RESET_PC;
            first_acc_cyc = -1;
            first_del_cyc = -1;
        end else if (redir) begin
            sb.delete();
            model_pc = rpc;
        end
        tests_run++;
        if (sb.size() > DEPTH) begin
            tests_failed++;
            $display("FAIL overflow: %0d fetches outstanding, limit %0d", sb.size(), DEPTH);
        end
        cyc++;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        lat = 1;
        resp_en = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (obs_req_valid !== 1'b0 || obs_ins_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_quiet: req_i_valid=%b ins_valid=%b expected 0/0", obs_req_valid, obs_ins_valid);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (obs_req_valid !== 1'b1 || obs_iaddr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL first_fetch: req_i_valid=%b Iaddr=%h expected 1/%h", obs_req_valid, obs_iaddr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int d0;
        d0 = n_del;
        stream(20);
        tests_run++;
        if (n_del - d0 < 15) begin
            tests_failed++;
            $display("FAIL stream_rate: %0d words delivered in 20 cycles, expected >= 15", n_del - d0);
        end
    endtask

    task automatic test_stall();
        int d0;
        do_reset();
        stream(5);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_req_valid !== 1'b0 || sb.size() != DEPTH || mem_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stall_fill: req_i_valid=%b buffered=%0d pending=%0d expected 0/%0d/0",
                     obs_req_valid, sb.size(), mem_q.size(), DEPTH);
        end
        d0 = n_del;
        stream(10);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (sb.size() != 0 || n_del - d0 < 10) begin
            tests_failed++;
            $display("FAIL stall_drain: left=%0d delivered=%0d expected 0/>=10", sb.size(), n_del - d0);
        end
    endtask

    task automatic test_redirect_inflight();
        int d0;
        int guard;
        do_reset();
        lat = 5;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (mem_q.size() != 3) begin
            tests_failed++;
            $display("FAIL inflight_setup: %0d in flight, expected 3", mem_q.size());
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        d0 = n_del;
        guard = 0;
        while (n_del == d0 && guard < 40) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        tests_run++;
        if (n_del == d0 || last_del_pc !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL redirect_first: delivered=%0d pc_out=%h expected pc 00000100", n_del - d0, last_del_pc);
        end
    endtask

    task automatic test_redirect_collide();
        int d0;
        int guard;
        do_reset();
        stream(6);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0500);
        tests_run++;
        if (obs_resp !== 1'b1) begin
            tests_failed++;
            $display("FAIL collide_setup: resp_i_valid=%b in redirect cycle, expected 1", obs_resp);
        end
        d0 = n_del;
        guard = 0;
        while (n_del == d0 && guard < 20) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        tests_run++;
        if (n_del == d0 || last_del_pc !== 32'h0000_0500) begin
            tests_failed++;
            $display("FAIL collide_first: delivered=%0d pc_out=%h expected pc 00000500", n_del - d0, last_del_pc);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int guard;
        do_reset();
        lat = 2;
        stream(6);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        d0 = n_del;
        guard = 0;
        while (n_del == d0 && guard < 30) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        tests_run++;
        if (n_del == d0 || last_del_pc !== 32'h0000_0300) begin
            tests_failed++;
            $display("FAIL b2b_first: delivered=%0d pc_out=%h expected pc 00000300", n_del - d0, last_del_pc);
        end
        stream(15);
        tests_run++;
        if (dut.state_r !== RUN) begin
            tests_failed++;
            $display("FAIL b2b_state: state=%0d expected RUN", dut.state_r);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        do_reset();
        guard = 0;
        while (model_pc !== 32'h0000_0040 && guard < 40) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        tests_run++;
        if (model_pc !== 32'h0000_0040) begin
            tests_failed++;
            $display("FAIL midrst_reach: fetch PC=%h expected 00000040", model_pc);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (obs_ins_valid !== 1'b0 || obs_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_empty: ins_valid=%b req_i_valid=%b expected 0/0", obs_ins_valid, obs_req_valid);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (obs_req_valid !== 1'b1 || obs_iaddr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL midrst_restart: req_i_valid=%b Iaddr=%h expected 1/%h", obs_req_valid, obs_iaddr, RESET_PC);
        end
    endtask

    task automatic test_latency();
        int exp_lat;
`ifdef FETCH_BYPASS_EN
        exp_lat = 1;
`else
        exp_lat = 2;
`endif
        do_reset();
        stream(6);
        tests_run++;
        if (first_acc_cyc < 0 || first_del_cyc < 0 || first_del_cyc - first_acc_cyc != exp_lat) begin
            tests_failed++;
            $display("FAIL latency: accept@%0d deliver@%0d expected distance %0d",
                     first_acc_cyc, first_del_cyc, exp_lat);
        end
    endtask

    task automatic test_random();
        int d0;
        logic [31:0] rpc;
        do_reset();
        d0 = n_del;
        for (int i = 0; i < 2000; i++) begin
            lat = $urandom_range(1, 3);
            resp_en = ($urandom_range(0, 9) < 7);
            rpc = 32'h0000_1000 + 32'($urandom_range(0, 63)) * 32'd4;
            cycle(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 4, rpc);
        end
        resp_en = 1'b1;
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (sb.size() != 0 || mem_q.size() != 0 || n_del - d0 < 200) begin
            tests_failed++;
            $display("FAIL random_drain: left=%0d pending=%0d delivered=%0d expected 0/0/>=200",
                     sb.size(), mem_q.size(), n_del - d0);
        end
    endtask

    initial begin
        mem_bus.req_i_ready  = 1'b0;
        mem_bus.resp_i_valid = 1'b0;
        mem_bus.Iin          = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_back_to_back();
        test_mid_reset();
        test_latency();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
